// File: rtl/stream_pair_aligner.sv
// rtl/stream_pair_aligner.sv - pairs A/B pixel streams by (row,col) and paces the aligned output
module stream_pair_aligner #(
   parameter int A_WIDTH        = 16,
   parameter int B_WIDTH        = 16,
   parameter int DEPTH          = 8,
   parameter int CLKS_PER_PIXEL = 1
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [A_WIDTH-1:0] a_pixel_i,
   input  logic               a_valid_i,
   input  logic [15:0]        a_row_i,
   input  logic [15:0]        a_col_i,
   input  logic [B_WIDTH-1:0] b_pixel_i,
   input  logic               b_valid_i,
   input  logic [15:0]        b_row_i,
   input  logic [15:0]        b_col_i,
   output logic [A_WIDTH-1:0] a_pixel_o,
   output logic [B_WIDTH-1:0] b_pixel_o,
   output logic               valid_o,
   output logic [15:0]        row_o,
   output logic [15:0]        col_o,
   output logic               a_ovf_o,
   output logic               b_ovf_o,
   output logic [15:0]        drop_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
   localparam logic [PW-1:0] PACE_LOAD = PW'(CLKS_PER_PIXEL - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

   // Each entry holds {pixel, row, col}; the low 32 bits form the raster key.
   logic [A_WIDTH+31:0] a_mem [DEPTH];
   logic [B_WIDTH+31:0] b_mem [DEPTH];
   logic [AW-1:0]       a_wr, a_rd, b_wr, b_rd;
   logic [AW:0]         a_cnt, b_cnt;
   logic [PW-1:0]       pace;

   logic [31:0]         key_a, key_b;
   logic [A_WIDTH-1:0]  head_a_px;
   logic [B_WIDTH-1:0]  head_b_px;
   logic                pop_a, pop_b, emit, discard;
   logic                push_a, push_b;

   assign key_a     = a_mem[a_rd][31:0];
   assign key_b     = b_mem[b_rd][31:0];
   assign head_a_px = a_mem[a_rd][A_WIDTH+31:32];
   assign head_b_px = b_mem[b_rd][B_WIDTH+31:32];

   always_comb begin
      pop_a   = 1'b0;
      pop_b   = 1'b0;
      emit    = 1'b0;
      discard = 1'b0;
      if (a_cnt != '0 && b_cnt != '0) begin
         if (key_a == key_b) begin
            if (pace == '0) begin
               emit  = 1'b1;
               pop_a = 1'b1;
               pop_b = 1'b1;
            end
         end else if (key_a < key_b) begin
            pop_a   = 1'b1;
            discard = 1'b1;
         end else begin
            pop_b   = 1'b1;
            discard = 1'b1;
         end
      end
   end

   // A full FIFO still accepts a write when its head leaves in the same cycle.
   assign push_a = a_valid_i && ((a_cnt != FULL_CNT) || pop_a);
   assign push_b = b_valid_i && ((b_cnt != FULL_CNT) || pop_b);

   always_ff @(posedge clk_i) begin
      if (rst_n_i && push_a) a_mem[a_wr] <= {a_pixel_i, a_row_i, a_col_i};
      if (rst_n_i && push_b) b_mem[b_wr] <= {b_pixel_i, b_row_i, b_col_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         a_wr       <= '0;
         a_rd       <= '0;
         a_cnt      <= '0;
         b_wr       <= '0;
         b_rd       <= '0;
         b_cnt      <= '0;
         pace       <= '0;
         valid_o    <= 1'b0;
         a_pixel_o  <= '0;
         b_pixel_o  <= '0;
         row_o      <= '0;
         col_o      <= '0;
         a_ovf_o    <= 1'b0;
         b_ovf_o    <= 1'b0;
         drop_cnt_o <= '0;
      end else begin
         if (push_a) a_wr <= a_wr + 1'b1;
         if (pop_a)  a_rd <= a_rd + 1'b1;
         case ({push_a, pop_a})
            2'b10:   a_cnt <= a_cnt + 1'b1;
            2'b01:   a_cnt <= a_cnt - 1'b1;
            default: ;
         endcase
         if (push_b) b_wr <= b_wr + 1'b1;
         if (pop_b)  b_rd <= b_rd + 1'b1;
         case ({push_b, pop_b})
            2'b10:   b_cnt <= b_cnt + 1'b1;
            2'b01:   b_cnt <= b_cnt - 1'b1;
            default: ;
         endcase
         if (a_valid_i && !push_a) a_ovf_o <= 1'b1;
         if (b_valid_i && !push_b) b_ovf_o <= 1'b1;

         if (emit)              pace <= PACE_LOAD;
         else if (pace != '0)   pace <= pace - 1'b1;

         if (discard && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;

         // Row/col come from A; equality with B is what made the emit possible.
         valid_o <= emit;
         if (emit) begin
            a_pixel_o <= head_a_px;
            b_pixel_o <= head_b_px;
            row_o     <= key_a[31:16];
            col_o     <= key_a[15:0];
         end
      end
   end
endmodule

// File: tb/tb_stream_pair_aligner.sv
// tb/tb_stream_pair_aligner.sv - randomized and directed checks of stream_pair_aligner against a merge model
module tb_stream_pair_aligner;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        a_v, b_v;
   logic [15:0] a_px, a_row, a_col, b_px, b_row, b_col;

   logic [15:0] p1_a, p1_b, r1, c1, d1, p3_a, p3_b, r3, c3, d3;
   logic        v1, ao1, bo1, v3, ao3, bo3;

   stream_pair_aligner #(.A_WIDTH(16), .B_WIDTH(16), .DEPTH(8), .CLKS_PER_PIXEL(1)) u1 (
      .clk_i(clk), .rst_n_i(rst_n),
      .a_pixel_i(a_px), .a_valid_i(a_v), .a_row_i(a_row), .a_col_i(a_col),
      .b_pixel_i(b_px), .b_valid_i(b_v), .b_row_i(b_row), .b_col_i(b_col),
      .a_pixel_o(p1_a), .b_pixel_o(p1_b), .valid_o(v1), .row_o(r1), .col_o(c1),
      .a_ovf_o(ao1), .b_ovf_o(bo1), .drop_cnt_o(d1));

   stream_pair_aligner #(.A_WIDTH(16), .B_WIDTH(16), .DEPTH(8), .CLKS_PER_PIXEL(3)) u3 (
      .clk_i(clk), .rst_n_i(rst_n),
      .a_pixel_i(a_px), .a_valid_i(a_v), .a_row_i(a_row), .a_col_i(a_col),
      .b_pixel_i(b_px), .b_valid_i(b_v), .b_row_i(b_row), .b_col_i(b_col),
      .a_pixel_o(p3_a), .b_pixel_o(p3_b), .valid_o(v3), .row_o(r3), .col_o(c3),
      .a_ovf_o(ao3), .b_ovf_o(bo3), .drop_cnt_o(d3));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [63:0] got1[$], got3[$];
   int          t1[$], t3[$];
   int          cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (v1) begin got1.push_back({p1_a, p1_b, r1, c1}); t1.push_back(cyc); end
      if (v3) begin got3.push_back({p3_a, p3_b, r3, c3}); t3.push_back(cyc); end
   end

   // Streams as written by the bench, entries {pixel,row,col}.
   logic [47:0] qa[$], qb[$];
   logic [63:0] expq[$];
   int          exp_drops;

   // Reference: ordered merge of two raster-ordered key lists.
   task automatic model();
      int i = 0;
      int j = 0;
      logic [31:0] ka, kb;
      expq.delete();
      exp_drops = 0;
      while (i < qa.size() && j < qb.size()) begin
         ka = qa[i][31:0];
         kb = qb[j][31:0];
         if (ka == kb) begin
            expq.push_back({qa[i][47:32], qb[j][47:32], ka});
            i++; j++;
         end else if (ka < kb) begin
            i++; exp_drops++;
         end else begin
            j++; exp_drops++;
         end
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      a_v = 1'b0;
      b_v = 1'b0;
   endtask

   task automatic put(input bit va, input logic [15:0] ar, ac, ap,
                      input bit vb, input logic [15:0] br, bc, bp, input bit rec_a);
      a_v = va; a_row = ar; a_col = ac; a_px = ap;
      b_v = vb; b_row = br; b_col = bc; b_px = bp;
      if (va && rec_a) qa.push_back({ap, ar, ac});
      if (vb)          qb.push_back({bp, br, bc});
      tick();
   endtask

   task automatic do_reset(input int n);
      idle();
      rst_n = 1'b0;
      tick(n);
      rst_n = 1'b1;
      got1.delete(); got3.delete(); t1.delete(); t3.delete();
      qa.delete(); qb.delete();
   endtask

   task automatic check_all(input string tag, input bit with3);
      model();
      chk({tag, ":n1"}, got1.size(), expq.size());
      for (int k = 0; k < got1.size() && k < expq.size(); k++) chk({tag, ":pair1"}, got1[k], expq[k]);
      chk({tag, ":drop1"}, d1, exp_drops);
      if (with3) begin
         chk({tag, ":n3"}, got3.size(), expq.size());
         for (int k = 0; k < got3.size() && k < expq.size(); k++) chk({tag, ":pair3"}, got3[k], expq[k]);
         chk({tag, ":drop3"}, d3, exp_drops);
         for (int k = 1; k < t3.size(); k++) chk({tag, ":gap3"}, (t3[k] - t3[k-1]) >= 3, 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      idle();
      a_px = 0; a_row = 0; a_col = 0; b_px = 0; b_row = 0; b_col = 0;
      tick(3);
      chk("rst_valid", {v1, v3}, 0);
      chk("rst_data", {p1_a, p1_b, r1, c1}, 0);
      chk("rst_flags", {ao1, bo1, ao3, bo3, d1, d3}, 0);
      do_reset(1);

      // Matched streams with exact two-cycle latency on the CPP=1 instance.
      for (int i = 0; i < 10; i++) begin
         put(1, 0, 16'(i), 16'(i + 100), 1, 0, 16'(i), 16'(i + 200), 1);
         if (i >= 1) begin
            chk("lat_valid", v1, 1);
            chk("lat_pixel", p1_a, i - 1 + 100);
         end
      end
      idle();
      tick();
      chk("lat_last", {v1, p1_a}, {1'b1, 16'd109});
      tick(40);
      check_all("match", 1);
      chk("match_count", got1.size(), 10);
      do_reset(2);

      // B lags A by five cycles; only CPP=1 has the throughput for this.
      for (int t = 0; t < 15; t++)
         put(t < 10, 0, 16'(t), 16'(t + 1), t >= 5, 0, 16'(t - 5), 16'(t + 50), 1);
      idle();
      tick(40);
      check_all("skew", 0);
      chk("skew_ovf", {ao1, bo1}, 0);
      do_reset(2);

      // A(0,0) has no partner and must be discarded.
      put(1, 0, 0, 16'h11, 1, 0, 1, 16'h21, 1);
      put(1, 0, 1, 16'h12, 1, 0, 2, 16'h22, 1);
      put(1, 0, 2, 16'h13, 0, 0, 0, 0, 1);
      idle();
      tick(20);
      check_all("mism", 1);
      chk("mism_drop", d1, 1);
      do_reset(2);

      // Ten A writes into an eight-deep FIFO with B idle.
      for (int i = 0; i < 10; i++) begin
         put(1, 0, 16'(i), 16'(i + 300), 0, 0, 0, 0, i < 8);
         if (i == 7) chk("ovf_before", ao1, 0);
         if (i == 8) chk("ovf_after", ao1, 1);
      end
      idle();
      tick(2);
      for (int i = 0; i < 8; i++) put(0, 0, 0, 0, 1, 0, 16'(i), 16'(i + 400), 1);
      idle();
      tick(40);
      check_all("ovf", 1);
      chk("ovf_flags", {ao1, bo1, ao3, bo3}, 4'b1010);
      do_reset(2);

      // Four back-to-back matched pixels on the paced instance.
      for (int i = 0; i < 4; i++) put(1, 2, 16'(i), 16'(i + 7), 1, 2, 16'(i), 16'(i + 9), 1);
      idle();
      tick(20);
      check_all("pace", 1);
      chk("pace_count", got3.size(), 4);
      do_reset(2);

      // Reset with A buffered; a later B(0,0) must not pair with stale data.
      for (int i = 0; i < 4; i++) put(1, 0, 16'(i), 16'(i + 500), 0, 0, 0, 0, 1);
      idle();
      tick();
      do_reset(1);
      put(0, 0, 0, 0, 1, 0, 0, 16'h55, 1);
      idle();
      tick(10);
      chk("rstmid_n", got1.size() + got3.size(), 0);
      chk("rstmid_data", {p1_a, p1_b, r1, c1}, 0);
      chk("rstmid_flags", {v1, v3, ao1, bo1, d1, d3}, 0);
      do_reset(2);

      // Random slot-aligned streams, each key present in A and/or B at random.
      for (int s = 0; s < 60; s++) begin
         put($urandom_range(0, 4) != 0, 16'(s / 5), 16'((s % 5) * 7), 16'($urandom),
             $urandom_range(0, 4) != 0, 16'(s / 5), 16'((s % 5) * 7), 16'($urandom), 1);
         idle();
         tick(3);
      end
      tick(20);
      check_all("rand", 1);
      chk("rand_ovf", {ao1, bo1, ao3, bo3}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
